// File: rtl/touch_multi_reader_pkg.sv
// Shared types and register map for the multi-point touch panel reader.
package touch_pkg;

    typedef enum logic [2:0] {
        S_INIT_VID = 3'd0,
        S_IDLE     = 3'd1,
        S_RD_GEST  = 3'd2,
        S_RD_STAT  = 3'd3,
        S_RD_PT    = 3'd4,
        S_PUBLISH  = 3'd5,
        S_WAIT_REL = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        B_XH = 2'd0,
        B_XL = 2'd1,
        B_YH = 2'd2,
        B_YL = 2'd3
    } byte_e;

    // Only the fields the panel defines are kept; XH[5:4] is reserved.
    typedef struct packed {
        logic [1:0]  evt;
        logic [3:0]  id;
        logic [11:0] x;
        logic [11:0] y;
    } point_t;

    localparam logic [7:0] REG_VENDOR  = 8'd168;
    localparam logic [7:0] REG_GEST    = 8'd1;
    localparam logic [7:0] REG_STAT    = 8'd2;
    localparam logic [7:0] REG_PT_BASE = 8'd3;

    // Register address of byte b of point i; wraps modulo 256.
    function automatic logic [7:0] pt_addr(input logic [3:0] i, input byte_e b, input logic [7:0] stride);
        return REG_PT_BASE + 8'(stride * {4'd0, i}) + {6'd0, b};
    endfunction

endpackage

// File: rtl/touch_multi_reader_if.sv
// Byte-read handshake between the touch reader and the external I2C master.
interface touch_multi_reader_if;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_done;

    modport master (output rd_start, output rd_addr, input rd_data, input rd_done);
    modport slave  (input rd_start, input rd_addr, output rd_data, output rd_done);
endinterface

// File: rtl/touch_multi_reader_int_sync.sv
// Two-flop synchroniser for the asynchronous, active-low panel interrupt.
module touch_int_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw input through the two stages.
    always_comb begin
        sync_d = {sync_q[0], async_in};
    end

    // Resets to the inactive (high) level so no frame starts spuriously.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[1];
endmodule

// File: rtl/touch_multi_reader.sv
// Multi-point touch reader: fetches gesture, count and point records byte by byte
// and publishes a complete frame atomically with a one-cycle update strobe.
module touch_multi_reader
    import touch_pkg::*;
#(
    parameter int MAX_POINTS     = 5,
    parameter int COORD_W        = 12,
    parameter int REG_STRIDE     = 6,
    parameter int POLL_MODE      = 0,
    parameter int POLL_CYCLES    = 500000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            touch_int,
    touch_multi_reader_if.master            rd,
    output logic [MAX_POINTS*COORD_W-1:0]   touch_x,
    output logic [MAX_POINTS*COORD_W-1:0]   touch_y,
    output logic [MAX_POINTS*4-1:0]         touch_id,
    output logic [MAX_POINTS*2-1:0]         touch_evt,
    output logic [MAX_POINTS-1:0]           touch_valid,
    output logic [3:0]                      touch_count,
    output logic [7:0]                      gesture,
    output logic [7:0]                      vendor_id,
    output logic                            update,
    output logic                            rd_err,
    output logic                            busy
);

    localparam logic [3:0]  MAX_CNT   = 4'(MAX_POINTS);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic [COORD_W-1:0] fit_coord(input logic [11:0] raw);
        return COORD_W'(raw);
    endfunction

    state_e                          state_q, state_d;
    logic                            rd_start_q, rd_start_d;
    logic [7:0]                      rd_addr_q, rd_addr_d;
    logic [31:0]                     tmo_cnt_q, tmo_cnt_d;
    logic [31:0]                     poll_cnt_q, poll_cnt_d;
    logic [3:0]                      cnt_sh_q, cnt_sh_d;
    logic [3:0]                      pt_idx_q, pt_idx_d;
    byte_e                           byte_q, byte_d;
    logic [7:0]                      gest_sh_q, gest_sh_d;
    point_t                          pt_sh_q [MAX_POINTS];
    point_t                          pt_sh_d [MAX_POINTS];
    logic [MAX_POINTS*COORD_W-1:0]   touch_x_q, touch_x_d;
    logic [MAX_POINTS*COORD_W-1:0]   touch_y_q, touch_y_d;
    logic [MAX_POINTS*4-1:0]         touch_id_q, touch_id_d;
    logic [MAX_POINTS*2-1:0]         touch_evt_q, touch_evt_d;
    logic [MAX_POINTS-1:0]           touch_valid_q, touch_valid_d;
    logic [3:0]                      touch_count_q, touch_count_d;
    logic [7:0]                      gesture_q, gesture_d;
    logic [7:0]                      vendor_id_q, vendor_id_d;
    logic                            update_q, update_d;
    logic                            rd_err_q, rd_err_d;
    logic                            busy_q, busy_d;

    logic                            int_sync_s;
    logic                            in_read_s;
    logic                            fire_s;
    logic                            tmo_s;
    logic                            poll_exp_s;
    logic [7:0]                      cur_addr_s;
    logic [3:0]                      stat_cnt_s;

    touch_int_sync u_int_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (touch_int),
        .sync_out (int_sync_s)
    );

    // Address of the byte the current state fetches, and the clamped point count.
    always_comb begin
        in_read_s  = 1'b1;
        cur_addr_s = rd_addr_q;
        case (state_q)
            S_INIT_VID: cur_addr_s = REG_VENDOR;
            S_RD_GEST:  cur_addr_s = REG_GEST;
            S_RD_STAT:  cur_addr_s = REG_STAT;
            S_RD_PT:    cur_addr_s = pt_addr(pt_idx_q, byte_q, 8'(REG_STRIDE));
            default:    in_read_s  = 1'b0;
        endcase
        if (rd.rd_data[3:0] > MAX_CNT) begin
            stat_cnt_s = MAX_CNT;
        end else begin
            stat_cnt_s = rd.rd_data[3:0];
        end
        fire_s     = rd_start_q & rd.rd_done;
        tmo_s      = rd_start_q & ~rd.rd_done & (tmo_cnt_q == TMO_LAST);
        poll_exp_s = (poll_cnt_q == POLL_LAST);
    end

    // Next-state, handshake and publish logic.
    always_comb begin
        state_d       = state_q;
        rd_start_d    = rd_start_q;
        rd_addr_d     = rd_addr_q;
        cnt_sh_d      = cnt_sh_q;
        pt_idx_d      = pt_idx_q;
        byte_d        = byte_q;
        gest_sh_d     = gest_sh_q;
        pt_sh_d       = pt_sh_q;
        touch_x_d     = touch_x_q;
        touch_y_d     = touch_y_q;
        touch_id_d    = touch_id_q;
        touch_evt_d   = touch_evt_q;
        touch_valid_d = touch_valid_q;
        touch_count_d = touch_count_q;
        gesture_d     = gesture_q;
        vendor_id_d   = vendor_id_q;
        update_d      = 1'b0;
        rd_err_d      = 1'b0;

        if (in_read_s) begin
            if (!rd_start_q) begin
                rd_start_d = 1'b1;
                rd_addr_d  = cur_addr_s;
            end else if (fire_s) begin
                rd_start_d = 1'b0;
                case (state_q)
                    S_INIT_VID: begin
                        vendor_id_d = rd.rd_data;
                        state_d     = S_IDLE;
                    end
                    S_RD_GEST: begin
                        gest_sh_d = rd.rd_data;
                        state_d   = S_RD_STAT;
                    end
                    S_RD_STAT: begin
                        cnt_sh_d = stat_cnt_s;
                        pt_idx_d = 4'd0;
                        byte_d   = B_XH;
                        state_d  = (stat_cnt_s == 4'd0) ? S_PUBLISH : S_RD_PT;
                    end
                    S_RD_PT: begin
                        for (int i = 0; i < MAX_POINTS; i++) begin
                            if (int'(pt_idx_q) == i) begin
                                case (byte_q)
                                    B_XH: begin
                                        pt_sh_d[i].evt    = rd.rd_data[7:6];
                                        pt_sh_d[i].x[11:8] = rd.rd_data[3:0];
                                    end
                                    B_XL: pt_sh_d[i].x[7:0] = rd.rd_data;
                                    B_YH: begin
                                        pt_sh_d[i].id      = rd.rd_data[7:4];
                                        pt_sh_d[i].y[11:8] = rd.rd_data[3:0];
                                    end
                                    B_YL: pt_sh_d[i].y[7:0] = rd.rd_data;
                                    default: pt_sh_d[i] = pt_sh_q[i];
                                endcase
                            end else begin
                                pt_sh_d[i] = pt_sh_q[i];
                            end
                        end
                        case (byte_q)
                            B_XH: byte_d = B_XL;
                            B_XL: byte_d = B_YH;
                            B_YH: byte_d = B_YL;
                            default: begin
                                byte_d = B_XH;
                                if (pt_idx_q + 4'd1 == cnt_sh_q) begin
                                    state_d = S_PUBLISH;
                                end else begin
                                    pt_idx_d = pt_idx_q + 4'd1;
                                end
                            end
                        endcase
                    end
                    default: state_d = S_IDLE;
                endcase
            end else if (tmo_s) begin
                // Abandon the frame; a failed vendor read is simply retried.
                rd_start_d = 1'b0;
                rd_err_d   = 1'b1;
                state_d    = (state_q == S_INIT_VID) ? S_INIT_VID : S_IDLE;
            end else begin
                rd_start_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (POLL_MODE != 0) begin
                        state_d = poll_exp_s ? S_RD_GEST : S_IDLE;
                    end else begin
                        state_d = int_sync_s ? S_IDLE : S_RD_GEST;
                    end
                end
                S_PUBLISH: begin
                    for (int i = 0; i < MAX_POINTS; i++) begin
                        if (i < int'(cnt_sh_q)) begin
                            touch_x_d[i*COORD_W +: COORD_W] = fit_coord(pt_sh_q[i].x);
                            touch_y_d[i*COORD_W +: COORD_W] = fit_coord(pt_sh_q[i].y);
                            touch_id_d[i*4 +: 4]            = pt_sh_q[i].id;
                            touch_evt_d[i*2 +: 2]           = pt_sh_q[i].evt;
                            touch_valid_d[i]                = 1'b1;
                        end else begin
                            touch_valid_d[i] = 1'b0;
                        end
                    end
                    touch_count_d = cnt_sh_q;
                    gesture_d     = gest_sh_q;
                    update_d      = 1'b1;
                    state_d       = (POLL_MODE != 0) ? S_IDLE : S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (int_sync_s) begin
                        state_d = S_IDLE;
                    end else if (poll_exp_s) begin
                        state_d = S_RD_GEST;
                    end else begin
                        state_d = S_WAIT_REL;
                    end
                end
                default: state_d = S_INIT_VID;
            endcase
        end

        tmo_cnt_d = rd_start_q ? (tmo_cnt_q + 32'd1) : 32'd0;
        if ((state_d == S_IDLE || state_d == S_WAIT_REL) && (state_d != state_q)) begin
            poll_cnt_d = 32'd0;
        end else begin
            poll_cnt_d = poll_cnt_q + 32'd1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT_VID;
            rd_start_q    <= 1'b0;
            rd_addr_q     <= 8'd0;
            tmo_cnt_q     <= 32'd0;
            poll_cnt_q    <= 32'd0;
            cnt_sh_q      <= 4'd0;
            pt_idx_q      <= 4'd0;
            byte_q        <= B_XH;
            gest_sh_q     <= 8'd0;
            for (int i = 0; i < MAX_POINTS; i++) begin
                pt_sh_q[i] <= '0;
            end
            touch_x_q     <= '0;
            touch_y_q     <= '0;
            touch_id_q    <= '0;
            touch_evt_q   <= '0;
            touch_valid_q <= '0;
            touch_count_q <= 4'd0;
            gesture_q     <= 8'd0;
            vendor_id_q   <= 8'd0;
            update_q      <= 1'b0;
            rd_err_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_start_q    <= rd_start_d;
            rd_addr_q     <= rd_addr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            cnt_sh_q      <= cnt_sh_d;
            pt_idx_q      <= pt_idx_d;
            byte_q        <= byte_d;
            gest_sh_q     <= gest_sh_d;
            pt_sh_q       <= pt_sh_d;
            touch_x_q     <= touch_x_d;
            touch_y_q     <= touch_y_d;
            touch_id_q    <= touch_id_d;
            touch_evt_q   <= touch_evt_d;
            touch_valid_q <= touch_valid_d;
            touch_count_q <= touch_count_d;
            gesture_q     <= gesture_d;
            vendor_id_q   <= vendor_id_d;
            update_q      <= update_d;
            rd_err_q      <= rd_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rd.rd_start   = rd_start_q;
    assign rd.rd_addr    = rd_addr_q;
    assign touch_x       = touch_x_q;
    assign touch_y       = touch_y_q;
    assign touch_id      = touch_id_q;
    assign touch_evt     = touch_evt_q;
    assign touch_valid   = touch_valid_q;
    assign touch_count   = touch_count_q;
    assign gesture       = gesture_q;
    assign vendor_id     = vendor_id_q;
    assign update        = update_q;
    assign rd_err        = rd_err_q;
    assign busy          = busy_q;

endmodule
